adc_peak_window_detect: RTL and testbench

- Parametrised successor to the fixed-mode ADC max detector for the RSR/PSR front end.
- Takes all ADC cores' parallel sample lanes and groups cores into output channels by a runtime parameter instead of compile-time defines.
- Tracks windowed peak max, peak min and full-scale clip count per channel, in unsigned or signed format.
- Results are published once per programmable window, with a one-cycle valid strobe, to the gain-control and status registers.

---
 rtl/adc_peak_window_detect.sv | 150 +++++++++++++++
 tb/tb_adc_peak_window_detect.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adc_peak_window_detect.sv
// adc_peak_window_detect: per-channel windowed peak max/min and full-scale clip count over grouped ADC cores.
module adc_peak_window_detect #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int LANES = 8,
  parameter int CORES = 4,
  parameter int GROUP = 1,
  parameter int SIGNED_MODE = 0,
  parameter int WIN_W = 16,
  localparam int NCH = CORES / GROUP
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CORES*LANES*ADC_DATA_WIDTH-1:0] adc_data_i,
  input  logic                                  adc_valid_i,
  input  logic [WIN_W-1:0]                      win_len_i,
  input  logic                                  clear_i,
  output logic [NCH*ADC_DATA_WIDTH-1:0]         peak_max_o,
  output logic [NCH*ADC_DATA_WIDTH-1:0]         peak_min_o,
  output logic [NCH*WIN_W-1:0]                  clip_cnt_o,
  output logic                                  peak_valid_o
);
  localparam int W = ADC_DATA_WIDTH;
  localparam int CW = $clog2(LANES + 1);
  localparam int GW = $clog2(GROUP * LANES + 1);
  localparam int SW = (WIN_W > GW ? WIN_W : GW) + 1;
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    return SIGNED_MODE != 0 ? $signed(a) > $signed(b) : a > b;
  endfunction
  function automatic logic fs(input logic [W-1:0] a);
    return SIGNED_MODE != 0 ? (a == {1'b1, {(W-1){1'b0}}} || a == {1'b0, {(W-1){1'b1}}}) : (a == '0 || &a);
  endfunction
  logic [CORES*LANES*W-1:0] s1_data;
  logic s1_v, s2_v, s3_v;
  logic [W-1:0] x;
  logic [W-1:0] c_max [CORES], c_min [CORES], s2_max [CORES], s2_min [CORES];
  logic [CW-1:0] c_clip [CORES], s2_clip [CORES];
  logic [W-1:0] g_max [NCH], g_min [NCH], s3_max [NCH], s3_min [NCH];
  logic [GW-1:0] g_clip [NCH], s3_clip [NCH];
  logic [W-1:0] acc_max [NCH], acc_min [NCH], m_max [NCH], m_min [NCH];
  logic [WIN_W-1:0] acc_clip [NCH], m_clip [NCH];
  logic [SW-1:0] sum [NCH];
  logic active, start, close;
  logic [WIN_W-1:0] cnt, len_q, eff_cnt, eff_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_data <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_data <= adc_data_i;
      s1_v <= adc_valid_i & ~clear_i;
    end
  always_comb begin
    x = '0;
    for (int c = 0; c < CORES; c++) begin
      c_max[c] = s1_data[c*LANES*W +: W];
      c_min[c] = c_max[c];
      c_clip[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        x = s1_data[(c*LANES+l)*W +: W];
        c_max[c] = gt(x, c_max[c]) ? x : c_max[c];
        c_min[c] = gt(c_min[c], x) ? x : c_min[c];
        c_clip[c] = c_clip[c] + CW'(fs(x));
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_v <= 1'b0;
      s2_max <= '{default: '0};
      s2_min <= '{default: '0};
      s2_clip <= '{default: '0};
    end else begin
      s2_v <= s1_v & ~clear_i;
      s2_max <= c_max;
      s2_min <= c_min;
      s2_clip <= c_clip;
    end
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      g_max[n] = s2_max[n*GROUP];
      g_min[n] = s2_min[n*GROUP];
      g_clip[n] = '0;
      for (int k = 0; k < GROUP; k++) begin
        g_max[n] = gt(s2_max[n*GROUP+k], g_max[n]) ? s2_max[n*GROUP+k] : g_max[n];
        g_min[n] = gt(g_min[n], s2_min[n*GROUP+k]) ? s2_min[n*GROUP+k] : g_min[n];
        g_clip[n] = g_clip[n] + GW'(s2_clip[n*GROUP+k]);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s3_v <= 1'b0;
      s3_max <= '{default: '0};
      s3_min <= '{default: '0};
      s3_clip <= '{default: '0};
    end else begin
      s3_v <= s2_v & ~clear_i;
      s3_max <= g_max;
      s3_min <= g_min;
      s3_clip <= g_clip;
    end
  // the first word of a window bypasses the accumulators so min/max need no identity value
  always_comb begin
    start = ~active;
    eff_cnt = start ? WIN_W'(1) : cnt + WIN_W'(1);
    eff_len = start ? (win_len_i == '0 ? WIN_W'(1) : win_len_i) : len_q;
    close = s3_v & (eff_cnt == eff_len);
    for (int n = 0; n < NCH; n++) begin
      m_max[n] = start || gt(s3_max[n], acc_max[n]) ? s3_max[n] : acc_max[n];
      m_min[n] = start || gt(acc_min[n], s3_min[n]) ? s3_min[n] : acc_min[n];
      sum[n] = (start ? SW'(0) : SW'(acc_clip[n])) + SW'(s3_clip[n]);
      m_clip[n] = sum[n] > SW'({WIN_W{1'b1}}) ? {WIN_W{1'b1}} : sum[n][WIN_W-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= 1'b0;
      cnt <= '0;
      len_q <= '0;
      acc_max <= '{default: '0};
      acc_min <= '{default: '0};
      acc_clip <= '{default: '0};
      peak_max_o <= '0;
      peak_min_o <= '0;
      clip_cnt_o <= '0;
      peak_valid_o <= 1'b0;
    end else begin
      peak_valid_o <= close & ~clear_i;
      if (clear_i) begin
        active <= 1'b0;
        cnt <= '0;
        acc_max <= '{default: '0};
        acc_min <= '{default: '0};
        acc_clip <= '{default: '0};
      end else if (s3_v) begin
        active <= ~close;
        cnt <= close ? '0 : eff_cnt;
        len_q <= eff_len;
        acc_max <= m_max;
        acc_min <= m_min;
        acc_clip <= m_clip;
        if (close)
          for (int n = 0; n < NCH; n++) begin
            peak_max_o[n*W +: W] <= m_max[n];
            peak_min_o[n*W +: W] <= m_min[n];
            clip_cnt_o[n*WIN_W +: WIN_W] <= m_clip[n];
          end
      end
    end
endmodule

// File: tb/tb_adc_peak_window_detect.sv
// tb_adc_peak_window_detect: directed table and corner-case sequences across three grouping/format configurations.
module tb_adc_peak_window_detect;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, clr = 1'b0;
  logic [255:0] data = '0;
  logic [15:0] wl = 16'd4;
  logic [31:0] pmax1, pmin1;
  logic [63:0] pclip1;
  logic [15:0] pmax2, pmin2;
  logic [31:0] pclip2;
  logic [7:0] pmax4, pmin4;
  logic [15:0] pclip4;
  logic pv1, pv2, pv4;
  int ncmp = 0, nfail = 0;
  always #5 clk = ~clk;
  adc_peak_window_detect u1 (.clk(clk), .rst(rst), .adc_data_i(data), .adc_valid_i(valid), .win_len_i(wl), .clear_i(clr),
    .peak_max_o(pmax1), .peak_min_o(pmin1), .clip_cnt_o(pclip1), .peak_valid_o(pv1));
  adc_peak_window_detect #(.GROUP(2)) u2 (.clk(clk), .rst(rst), .adc_data_i(data), .adc_valid_i(valid), .win_len_i(wl), .clear_i(clr),
    .peak_max_o(pmax2), .peak_min_o(pmin2), .clip_cnt_o(pclip2), .peak_valid_o(pv2));
  adc_peak_window_detect #(.GROUP(4), .SIGNED_MODE(1)) u4 (.clk(clk), .rst(rst), .adc_data_i(data), .adc_valid_i(valid), .win_len_i(wl), .clear_i(clr),
    .peak_max_o(pmax4), .peak_min_o(pmin4), .clip_cnt_o(pclip4), .peak_valid_o(pv4));
  typedef struct {
    logic [255:0] d;
    logic v, c;
    logic [15:0] w;
    logic ev;
    logic [31:0] emax, emin;
    logic [63:0] eclip;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] em = '0, en = '0;
  logic [63:0] ec = '0;
  function automatic logic [255:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction
  function automatic logic [255:0] setb(input logic [255:0] d, input int c, input int l, input logic [7:0] b);
    d[(c*8+l)*8 +: 8] = b;
    return d;
  endfunction
  function automatic logic [255:0] mk1(input bit last);
    logic [255:0] d = fill(8'h20);
    for (int l = 0; l < 8; l++) d = setb(setb(d, 0, l, 8'h10 + 8'(l)), 1, l, 8'h40);
    return last ? setb(d, 0, 3, 8'h80) : d;
  endfunction
  task automatic add(input logic [255:0] d, input logic v, input logic c, input logic [15:0] w, input logic ev);
    tbl.push_back(vec_t'{d, v, c, w, ev, em, en, ec});
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive(input logic [255:0] d, input logic v, input logic c);
    data = d;
    valid = v;
    clr = c;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    drive(fill(8'hFF), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    logic [7:0] vals [3];
    logic [31:0] smax;
    logic [63:0] sclip;
    int first, nstb;
    vals = '{8'h01, 8'h00, 8'h7E};
    // window of 4 on unsigned four-channel, then clear colliding with a close
    for (int k = 0; k < 4; k++) add(mk1(k == 3), 1'b1, 1'b0, 16'd4, 1'b0);
    for (int k = 0; k < 3; k++) add(fill(8'hFF), 1'b0, 1'b0, 16'd4, 1'b0);
    em = 32'h20204080; en = 32'h20204010;
    add(fill(8'hFF), 1'b0, 1'b0, 16'd4, 1'b1);
    add(fill(8'hFF), 1'b0, 1'b0, 16'd4, 1'b0);
    add(fill(8'h22), 1'b1, 1'b0, 16'd2, 1'b0);
    add(fill(8'h22), 1'b1, 1'b0, 16'd2, 1'b0);
    for (int k = 0; k < 3; k++) add(fill(8'hFF), 1'b0, 1'b0, 16'd2, 1'b0);
    em = 32'h22222222; en = 32'h22222222;
    add(fill(8'hFF), 1'b0, 1'b0, 16'd2, 1'b1);
    add(fill(8'h44), 1'b1, 1'b0, 16'd2, 1'b0);
    add(fill(8'h44), 1'b1, 1'b1, 16'd2, 1'b0);
    add(fill(8'h11), 1'b1, 1'b0, 16'd2, 1'b0);
    add(fill(8'h11), 1'b1, 1'b0, 16'd2, 1'b0);
    for (int k = 0; k < 3; k++) add(fill(8'hFF), 1'b0, 1'b0, 16'd2, 1'b0);
    em = 32'h11111111; en = 32'h11111111;
    add(fill(8'hFF), 1'b0, 1'b0, 16'd2, 1'b1);
    add(fill(8'hFF), 1'b0, 1'b0, 16'd2, 1'b0);
    do_reset();
    tick();
    chk("rst_max1", pmax1, 0); chk("rst_min1", pmin1, 0); chk("rst_clip1", pclip1, 0); chk("rst_v1", pv1, 0);
    chk("rst_max2", pmax2, 0); chk("rst_clip4", pclip4, 0); chk("rst_v4", pv4, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      chk($sformatf("tbl%0d_valid", i), pv1, tbl[i].ev);
      chk($sformatf("tbl%0d_max", i), pmax1, tbl[i].emax);
      chk($sformatf("tbl%0d_min", i), pmin1, tbl[i].emin);
      chk($sformatf("tbl%0d_clip", i), pclip1, tbl[i].eclip);
      drive(tbl[i].d, tbl[i].v, tbl[i].c);
      wl = tbl[i].w;
    end
    // signed single channel: both extremes count as clips
    do_reset();
    wl = 16'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("sgn_valid%0d", i), pv4, i == 5);
      if (i == 5) begin
        chk("sgn_max", pmax4, 8'h7F); chk("sgn_min", pmin4, 8'h80); chk("sgn_clip", pclip4, 16'd2);
      end
      drive(i == 0 ? setb(setb(fill(8'h05), 0, 0, 8'h7F), 1, 2, 8'h80) : i == 1 ? fill(8'h05) : fill(8'hFF), i < 2, 1'b0);
    end
    // two channels with gapped valid; invalid cycles carry full-scale data
    do_reset();
    wl = 16'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("gap_valid%0d", i), pv2, i == 8);
      if (i == 8) begin
        chk("gap_max", pmax2, 16'h3250); chk("gap_min", pmin2, 16'h0130); chk("gap_clip", pclip2, 0);
      end
      drive(i == 0 ? fill(8'h30) : i == 2 ? setb(fill(8'h31), 1, 5, 8'h50) : i == 4 ? setb(fill(8'h32), 2, 0, 8'h01) : fill(8'hFF),
            i < 5 && i % 2 == 0, 1'b0);
    end
    // long full-scale run saturates the clip count
    do_reset();
    wl = 16'hFFFF;
    first = -1; nstb = 0; smax = '0; sclip = '0;
    for (int n = 0; n < 70000; n++) begin
      tick();
      if (pv1) begin
        nstb++;
        if (first < 0) begin first = n; smax = pmax1; sclip = pclip1; end
      end
      drive(fill(8'hFF), 1'b1, 1'b0);
    end
    chk("sat_first", first, 65538); chk("sat_nstrobe", nstb, 1);
    chk("sat_max", smax, 32'hFFFFFFFF); chk("sat_clip", sclip, 64'hFFFFFFFFFFFFFFFF);
    // win_len 0 acts as 1
    tick();
    drive(fill(8'hFF), 1'b0, 1'b1);
    wl = 16'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("len0_valid%0d", i), pv1, i >= 4 && i < 7);
      if (i >= 4 && i < 7) begin
        chk($sformatf("len0_max%0d", i), pmax1, {4{vals[i-4]}});
        chk($sformatf("len0_clip%0d", i), pclip1, vals[i-4] == 8'h00 ? {4{16'd8}} : 64'd0);
      end
      drive(i < 3 ? fill(vals[i]) : fill(8'hFF), i < 3, 1'b0);
    end
    // asynchronous reset in the middle of a window
    wl = 16'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(fill(8'hFF), 1'b1, 1'b0);
    end
    chk("arst_pre_max", pmax1, 32'h7E7E7E7E);
    #3 rst = 1'b1;
    #1;
    chk("arst_max", pmax1, 0); chk("arst_min", pmin1, 0); chk("arst_clip", pclip1, 0); chk("arst_v", pv1, 0);
    drive(fill(8'hFF), 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    wl = 16'd2;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("post_valid%0d", i), pv1, i == 5);
      if (i == 5) begin
        chk("post_max", pmax1, 32'h5A5A5A5A); chk("post_min", pmin1, 32'h5A5A5A5A); chk("post_clip", pclip1, 0);
      end
      drive(i < 2 ? fill(8'h5A) : fill(8'hFF), i < 2, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
